// File: rtl/spi_server.sv
// SPI master that sends an instruction word {rw, code, start_address, num_transactions}
// followed by N data words, either written from tx_data or read back into rx_data.
module spi_server #(
    parameter int MESSAGE_BIT_WIDTH       = 32,
    parameter int CODE_BIT_WIDTH          = 4,
    parameter int START_ADDRESS_BIT_WIDTH = 16,
    parameter int SCK_HALF_PERIOD         = 2,
    localparam int NT_W = MESSAGE_BIT_WIDTH - CODE_BIT_WIDTH - START_ADDRESS_BIT_WIDTH - 1
) (
    input  logic                               clk,
    input  logic                               RST_async,
    input  logic                               start,
    input  logic                               rw,
    input  logic [CODE_BIT_WIDTH-1:0]          code,
    input  logic [START_ADDRESS_BIT_WIDTH-1:0] start_address,
    input  logic [NT_W-1:0]                    num_transactions,
    input  logic                               client_idle,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       tx_data,
    output logic                               tx_data_req,
    output logic [MESSAGE_BIT_WIDTH-1:0]       rx_data,
    output logic                               rx_data_valid,
    output logic                               busy,
    output logic                               done,
    output logic                               SCK,
    output logic                               MOSI,
    input  logic                               MISO
);

    localparam int BIT_W = $clog2(MESSAGE_BIT_WIDTH);
    localparam int DIV_W = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MESSAGE_BIT_WIDTH - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StInstr  = 2'd1;
    localparam logic [1:0] StData   = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    if (NT_W < 1) begin : g_nt_w_check
        $error("spi_server: num_transactions field width must be at least 1");
    end
    if (SCK_HALF_PERIOD < 1) begin : g_half_check
        $error("spi_server: SCK_HALF_PERIOD must be at least 1");
    end
    if ((MESSAGE_BIT_WIDTH & (MESSAGE_BIT_WIDTH - 1)) != 0) begin : g_pow2_check
        $error("spi_server: MESSAGE_BIT_WIDTH must be a power of two");
    end

    logic [1:0]                   state_q, state_d;
    logic [DIV_W-1:0]             div_q, div_d;
    logic [BIT_W-1:0]             bit_q, bit_d;
    logic [NT_W-1:0]              word_q, word_d;
    logic                         sck_q, sck_d;
    logic [MESSAGE_BIT_WIDTH-1:0] shift_q, shift_d;
    logic [MESSAGE_BIT_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [MESSAGE_BIT_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                         rx_valid_q, rx_valid_d;
    logic                         rx_pend_q, rx_pend_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         rw_q, rw_d;
    logic                         sync1_q, sync2_q;

    // word_q holds the number of data words still to follow the current word.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        word_d      = word_q;
        sck_d       = sck_q;
        shift_d     = shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_pend_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rw_d        = rw_q;
        tx_data_req = 1'b0;

        if (rx_pend_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start && sync2_q) begin
                    rw_d    = rw;
                    shift_d = {rw, code, start_address, num_transactions};
                    word_d  = num_transactions;
                    bit_d   = '0;
                    div_d   = '0;
                    sck_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StInstr;
                end
            end
            StInstr, StData: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d      = 1'b1;
                        rx_shift_d = {rx_shift_q[MESSAGE_BIT_WIDTH-2:0], MISO};
                        rx_pend_d  = (state_q == StData) && rw_q && (bit_q == BIT_LAST);
                    end else begin
                        // Falling edge: the next bit goes onto MOSI together with SCK low.
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
                            if (word_q == '0) begin
                                shift_d = '0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = StFinish;
                            end else begin
                                word_d  = word_q - NT_W'(1);
                                state_d = StData;
                                if (rw_q) begin
                                    shift_d = '0;
                                end else begin
                                    tx_data_req = 1'b1;
                                    shift_d     = tx_data;
                                end
                            end
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            shift_d = shift_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST_async) begin
        if (RST_async) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            sck_q      <= 1'b0;
            shift_q    <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_pend_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            sck_q      <= sck_d;
            shift_q    <= shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_pend_q  <= rx_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rw_q       <= rw_d;
            sync1_q    <= client_idle;
            sync2_q    <= sync1_q;
        end
    end

    assign SCK           = sck_q;
    assign MOSI          = shift_q[MESSAGE_BIT_WIDTH-1];
    assign busy          = busy_q;
    assign done          = done_q;
    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_valid_q;

endmodule
